// File: rtl/e_mdu.sv
//------------------------------------------------------------------------------
// e_mdu : E-stage multiply/divide unit with HI/LO state and stall indication
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module e_mdu #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             md_stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int c_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int c_CNT_W      = $clog2(c_MAX_CYCLES + 1);

  localparam logic [c_CNT_W-1:0] c_MULT_CNT = c_CNT_W'(MULT_CYCLES);
  localparam logic [c_CNT_W-1:0] c_DIV_CNT  = c_CNT_W'(DIV_CYCLES);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  localparam logic [2:0] c_OP_NONE  = 3'd0;
  localparam logic [2:0] c_OP_MULT  = 3'd1;
  localparam logic [2:0] c_OP_MULTU = 3'd2;
  localparam logic [2:0] c_OP_DIV   = 3'd3;
  localparam logic [2:0] c_OP_DIVU  = 3'd4;
  localparam logic [2:0] c_OP_MTHI  = 3'd5;
  localparam logic [2:0] c_OP_MTLO  = 3'd6;

  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [2:0]         r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_busy;

  logic               w_multi_req;
  logic [2*WIDTH-1:0] w_prod_s;
  logic [2*WIDTH-1:0] w_prod_u;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH-1:0]   w_div_b;
  logic [WIDTH-1:0]   w_uq;
  logic [WIDTH-1:0]   w_ur;
  logic [WIDTH-1:0]   w_q;
  logic [WIDTH-1:0]   w_r;
  logic               w_res_wr;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;

  assign w_multi_req = start && (md_op >= c_OP_MULT) && (md_op <= c_OP_DIVU);
  assign md_stall    = r_busy || w_multi_req;
  assign busy        = r_busy;
  assign hi          = r_hi;
  assign lo          = r_lo;

  assign w_prod_s = $signed({{WIDTH{r_a[WIDTH-1]}}, r_a}) * $signed({{WIDTH{r_b[WIDTH-1]}}, r_b});
  assign w_prod_u = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};

  // Signed divide is done on magnitudes; this also yields the required
  // most-negative / -1 result (quotient = most-negative, remainder = 0).
  assign w_a_neg = (r_op == c_OP_DIV) && r_a[WIDTH-1];
  assign w_b_neg = (r_op == c_OP_DIV) && r_b[WIDTH-1];
  assign w_mag_a = w_a_neg ? -r_a : r_a;
  assign w_mag_b = w_b_neg ? -r_b : r_b;
  assign w_div_b = (w_mag_b == '0) ? WIDTH'(1) : w_mag_b;
  assign w_uq    = w_mag_a / w_div_b;
  assign w_ur    = w_mag_a % w_div_b;
  assign w_q     = (w_a_neg ^ w_b_neg) ? -w_uq : w_uq;
  assign w_r     = w_a_neg ? -w_ur : w_ur;

  always_comb begin
    w_res_wr = 1'b0;
    w_res_hi = r_hi;
    w_res_lo = r_lo;
    case (r_op)
      c_OP_MULT: begin
        w_res_wr = 1'b1;
        {w_res_hi, w_res_lo} = w_prod_s;
      end
      c_OP_MULTU: begin
        w_res_wr = 1'b1;
        {w_res_hi, w_res_lo} = w_prod_u;
      end
      c_OP_DIV, c_OP_DIVU: begin
        // Divide by zero leaves HI/LO untouched.
        w_res_wr = (r_b != '0);
        w_res_hi = w_r;
        w_res_lo = w_q;
      end
      default: begin
        w_res_wr = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_op   <= c_OP_NONE;
      r_a    <= '0;
      r_b    <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (r_busy) begin
      r_cnt <= r_cnt - c_CNT_ONE;
      if (r_cnt == c_CNT_ONE) begin
        r_busy <= 1'b0;
        if (w_res_wr) begin
          r_hi <= w_res_hi;
          r_lo <= w_res_lo;
        end
      end
    end else if (start) begin
      case (md_op)
        c_OP_MULT, c_OP_MULTU, c_OP_DIV, c_OP_DIVU: begin
          r_op   <= md_op;
          r_a    <= a;
          r_b    <= b;
          r_cnt  <= (md_op == c_OP_MULT || md_op == c_OP_MULTU) ? c_MULT_CNT : c_DIV_CNT;
          r_busy <= 1'b1;
        end
        c_OP_MTHI: r_hi <= a;
        c_OP_MTLO: r_lo <= a;
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/e_mdu.md
# e_mdu

Parametrised multiply/divide unit for the E stage of the five-stage pipeline, with HI/LO state. It executes mult/multu/div/divu as multi-cycle operations with configurable latency, and mthi/mtlo as single-cycle writes. It presents HI/LO to the E-stage result mux for mfhi/mflo, and a busy/stall indication to the stall unit. Results commit to HI/LO only when an operation completes.

## Interface
Parameters:
- WIDTH, 32, operand and HI/LO width (≥2)
- MULT_CYCLES, 5, cycles from accepted mult/multu to HI/LO update (≥1)
- DIV_CYCLES, 10, cycles from accepted div/divu to HI/LO update (≥1)

Ports:
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high; clears all state on the edge where it is high
- start  in  1  E-stage instruction is an MDU op; qualifies md_op
- md_op  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- a  in  WIDTH  forwarded rs value
- b  in  WIDTH  forwarded rt value
- busy  out  1  multi-cycle operation in flight
- md_stall  out  1  busy OR (start AND md_op in 1..4); consumed by the stall unit to hold any D-stage MDU instruction
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

## Operation
- Registers: hi, lo, op_r (latched op), a_r, b_r, cnt (width sized for max(MULT_CYCLES, DIV_CYCLES)), busy.
- Accept: on an edge with start=1, busy=0 and md_op in 1..4:
  - latch a, b and op into a_r, b_r, op_r
  - load cnt = MULT_CYCLES or DIV_CYCLES
  - set busy=1
- Count: while busy, cnt decrements each edge.
- Complete: on the edge where cnt==1, set busy=0 and write the result to hi/lo:
  - mult: {hi,lo} = signed a_r × signed b_r, 2·WIDTH-bit product
  - multu: unsigned product
  - div: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend
  - divu: unsigned quotient and remainder
  - signed overflow (a_r = most-negative, b_r = −1): lo = most-negative, hi = 0
  - b_r == 0 (div or divu): hi and lo keep their previous values; busy still runs the full DIV_CYCLES
- mthi/mtlo: on an edge with start=1, busy=0 and md_op 5 or 6, hi (or lo) = a. These complete in one cycle and never set busy.
- start while busy: ignored entirely, whatever md_op is. The pipeline guarantees no such request via md_stall; the block does not queue it.
- md_op 0 or 7 with start=1: no effect.
- hi/lo outputs reflect committed state only; intermediate results are never visible. mfhi/mflo in E read hi/lo directly.

## Timing
- Reset values: busy=0, hi=0, lo=0, cnt=0, op_r=0, a_r=0, b_r=0. md_stall=0 when start=0.
- Accept at edge T: busy=1 from after T through the edge T+N, where N = MULT_CYCLES or DIV_CYCLES. hi/lo change at edge T+N, and busy=0 after that same edge.
- busy is therefore high for exactly N cycles.
- A new operation can be accepted at edge T+N+1 at the earliest: the stalled D instruction reaches E on that cycle.
- md_stall is combinational from start/md_op and registered busy. It has no dependence on a/b.
- mthi/mtlo accepted at edge T: the new hi/lo is visible immediately after T, so an mfhi in the next E cycle reads it.
- Reset mid-operation: the operation is abandoned, busy drops, and hi/lo clear. Reset has priority over accept and complete on the same edge.
- Completion and a new start on the same edge: the start is ignored because busy is still 1 on that edge.

## Test plan
- Reset, then mult a=0xFFFFFFFE (−2), b=3 → busy high for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA; busy=0.
- multu a=0xFFFFFFFF, b=0xFFFFFFFF → after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
- div a=−7 (0xFFFFFFF9), b=2 → after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu on the same operands → lo=0x7FFFFFFC, hi=0x00000001.
- Edge cases:
  - div a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0
  - divu with b=0 after hi=5, lo=9 → busy for 10 cycles; hi=5, lo=9 unchanged
- mthi a=0x12345678 while idle → hi=0x12345678 on the next cycle, busy stays 0. mtlo and mult issued while busy → ignored; md_stall=1 throughout.
- Assert reset at cycle 3 of a div → busy=0, hi=lo=0 on the next cycle. Rerun with MULT_CYCLES=1, DIV_CYCLES=1 → busy high for exactly one cycle.
